// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: arbiter state encodings and Wishbone CTI constants shared by the stream blocks
package wb_stream_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_LINEAR  = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/wb_stream_watchdog.sv
// wb_stream_watchdog: saturating stall counter that flags expiry when the slave goes silent
module wb_stream_watchdog #(
    parameter int STALL_MAX = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic kick_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CW = STALL_MAX > 0 ? $clog2(STALL_MAX + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (!en_i || kick_i || clr_i) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
    // a response on the expiry cycle wins over the timeout
    assign expire_o = (STALL_MAX != 0) && en_i && !kick_i && cnt_q == CW'(STALL_MAX - 1);
endmodule

// File: rtl/wb_stream_arbiter.sv
// wb_stream_arbiter: two-master Wishbone arbiter with burst-aware release and stall watchdog
module wb_stream_arbiter
    import wb_stream_pkg::*;
#(
    parameter int WB_AW     = 32,
    parameter int WB_DW     = 32,
    parameter int STALL_MAX = 256
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [WB_AW-1:0]   m0_adr_i,
    input  logic [WB_DW-1:0]   m0_dat_i,
    input  logic [WB_DW/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic [2:0]         m0_cti_i,
    input  logic [1:0]         m0_bte_i,
    output logic [WB_DW-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_rty_o,
    input  logic [WB_AW-1:0]   m1_adr_i,
    input  logic [WB_DW-1:0]   m1_dat_i,
    input  logic [WB_DW/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic [2:0]         m1_cti_i,
    input  logic [1:0]         m1_bte_i,
    output logic [WB_DW-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_rty_o,
    output logic [WB_AW-1:0]   s_adr_o,
    output logic [WB_DW-1:0]   s_dat_o,
    output logic [WB_DW/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic [2:0]         s_cti_o,
    output logic [1:0]         s_bte_o,
    input  logic [WB_DW-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i,
    output logic [1:0]         grant_o,
    output logic               timeout_o
);
    arb_state_e state_q, state_d;
    logic last_q, last_d;
    logic owned, own1, own_cyc, oth_cyc, resp, rel, expire, live;
    logic [2:0] own_cti;

    assign owned   = state_q != ST_IDLE;
    assign own1    = state_q == ST_OWN1;
    assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign oth_cyc = own1 ? m0_cyc_i : m1_cyc_i;
    assign own_cti = own1 ? m1_cti_i : m0_cti_i;
    assign resp    = s_ack_i || s_err_i || s_rty_i;
    // classic cycles give up the bus on every ack so a streaming master cannot starve the other
    assign rel = owned && (!own_cyc || s_err_i || s_rty_i || expire ||
                 (s_ack_i && (own_cti == CTI_EOB || own_cti == CTI_CLASSIC)));

    wb_stream_watchdog #(.STALL_MAX(STALL_MAX)) u_wdog (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .en_i     (owned),
        .kick_i   (resp),
        .clr_i    (rel),
        .expire_o (expire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            state_d = (m0_cyc_i && m1_cyc_i) ? (last_q ? ST_OWN0 : ST_OWN1) :
                      m0_cyc_i ? ST_OWN0 : m1_cyc_i ? ST_OWN1 : ST_IDLE;
        end else if (rel) begin
            last_d  = own1;
            state_d = oth_cyc ? (own1 ? ST_OWN0 : ST_OWN1) : own_cyc ? state_q : ST_IDLE;
        end
    end

    // responses are suppressed while reset is asserted, even before the reset edge lands
    assign live = owned && wb_rst_ni;

    always_comb begin
        s_adr_o   = owned ? (own1 ? m1_adr_i : m0_adr_i) : '0;
        s_dat_o   = owned ? (own1 ? m1_dat_i : m0_dat_i) : '0;
        s_sel_o   = owned ? (own1 ? m1_sel_i : m0_sel_i) : '0;
        s_we_o    = owned && (own1 ? m1_we_i : m0_we_i);
        s_cyc_o   = owned && own_cyc;
        s_stb_o   = owned && (own1 ? m1_stb_i : m0_stb_i);
        s_cti_o   = owned ? own_cti : CTI_CLASSIC;
        s_bte_o   = owned ? (own1 ? m1_bte_i : m0_bte_i) : '0;
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
        m0_ack_o  = live && !own1 && s_ack_i;
        m1_ack_o  = live && own1 && s_ack_i;
        m0_err_o  = live && !own1 && (s_err_i || expire);
        m1_err_o  = live && own1 && (s_err_i || expire);
        m0_rty_o  = live && !own1 && s_rty_i;
        m1_rty_o  = live && own1 && s_rty_i;
        timeout_o = live && expire;
        grant_o   = state_q;
    end
endmodule

// File: tb/tb_wb_stream_arbiter.sv
// tb_wb_stream_arbiter: directed per-cycle vectors for arbitration, release, watchdog and reset
module tb_wb_stream_arbiter;
    import wb_stream_pkg::*;
    localparam logic H = 1'b1, Z = 1'b0;
    localparam logic [1:0] N = 2'b00, P0 = 2'b01, P1 = 2'b10;
    localparam logic [2:0] CLA = CTI_CLASSIC, LIN = CTI_LINEAR, EOB = CTI_EOB;

    typedef struct packed {
        logic rst_n, c0;
        logic [2:0] t0;
        logic c1;
        logic [2:0] t1;
        logic ack, err, rty;
        logic [1:0] g, a, e, r;
        logic to, sc;
        logic [7:0] adr;
    } vec_t;

    vec_t vecs[$];
    int n_chk = 0, n_fail = 0;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] m0_adr = 32'hA0, m1_adr = 32'hB0;
    logic [31:0] m0_dat = 32'h11110000, m1_dat = 32'h22220000;
    logic [3:0] m0_sel = 4'hF, m1_sel = 4'h3;
    logic m0_we = 1'b1, m1_we = 1'b0;
    logic m0_cyc = 1'b0, m1_cyc = 1'b0;
    logic [2:0] m0_cti = 3'b000, m1_cti = 3'b000;
    logic [1:0] m0_bte = 2'b01, m1_bte = 2'b10;
    logic [31:0] s_dat = 32'h0;
    logic s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic [3:0] s_sel_o;
    logic s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [2:0] s_cti_o;
    logic [1:0] s_bte_o, grant_o;

    always #5 clk = ~clk;

    wb_stream_arbiter #(.WB_AW(32), .WB_DW(32), .STALL_MAX(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_cyc), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_cyc), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic add(input logic rn, c0, input logic [2:0] t0, input logic c1, input logic [2:0] t1,
                       input logic ack, err, rty, input logic [1:0] g, a, e, r,
                       input logic to, sc, input logic [7:0] adr);
        vecs.push_back({rn, c0, t0, c1, t1, ack, err, rty, g, a, e, r, to, sc, adr});
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // m0 linear burst of 4, final beat EOB, then cyc drops; ack in idle is dropped
        add(H, H, LIN, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        for (int k = 0; k < 3; k++) add(H, H, LIN, Z, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, H, EOB, Z, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, P0, N, N, N, Z, Z, 8'hA0);
        add(H, Z, CLA, Z, CLA, H, Z, Z, N, N, N, N, Z, Z, 8'h00);
        // reset, then both request: m0 first, EOB hands over to m1, classic acks alternate
        add(Z, Z, CLA, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        add(H, H, LIN, H, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        add(H, H, LIN, H, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, H, EOB, H, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, H, CLA, H, CLA, Z, Z, Z, P1, N, N, N, Z, H, 8'hB0);
        add(H, H, CLA, H, CLA, H, Z, Z, P1, P1, N, N, Z, H, 8'hB0);
        add(H, H, CLA, H, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, H, CLA, H, CLA, H, Z, Z, P1, P1, N, N, Z, H, 8'hB0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, P0, N, N, N, Z, Z, 8'hA0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        // watchdog: eighth silent owned cycle raises err and timeout for one cycle
        add(H, H, LIN, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        for (int k = 0; k < 7; k++) add(H, H, LIN, Z, CLA, Z, Z, Z, P0, N, N, N, Z, H, 8'hA0);
        add(H, H, LIN, Z, CLA, Z, Z, Z, P0, N, P0, N, H, H, 8'hA0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, P0, N, N, N, Z, Z, 8'hA0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        // ack on the expiry cycle wins
        add(H, H, LIN, Z, CLA, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        for (int k = 0; k < 7; k++) add(H, H, LIN, Z, CLA, Z, Z, Z, P0, N, N, N, Z, H, 8'hA0);
        add(H, H, LIN, Z, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(H, Z, CLA, Z, CLA, Z, Z, Z, P0, N, N, N, Z, Z, 8'hA0);
        // m1 owner: err and rty route only to m1, then cyc drop hands over to m0
        add(H, Z, CLA, H, LIN, Z, Z, Z, N, N, N, N, Z, Z, 8'h00);
        add(H, Z, CLA, H, LIN, Z, H, Z, P1, N, P1, N, Z, H, 8'hB0);
        add(H, Z, CLA, H, LIN, Z, Z, H, P1, N, N, P1, Z, H, 8'hB0);
        add(H, H, CLA, H, LIN, H, Z, Z, P1, P1, N, N, Z, H, 8'hB0);
        add(H, H, CLA, Z, LIN, Z, Z, Z, P1, N, N, N, Z, Z, 8'hB0);
        add(H, H, LIN, Z, CLA, Z, Z, Z, P0, N, N, N, Z, H, 8'hA0);
        // reset on beat 2 of a burst: no ack, bus dropped, last_owner back to 1
        add(H, H, LIN, Z, CLA, H, Z, Z, P0, P0, N, N, Z, H, 8'hA0);
        add(Z, H, LIN, Z, CLA, H, Z, Z, P0, N, N, N, Z, H, 8'hA0);
        add(H, H, LIN, H, CLA, H, Z, Z, N, N, N, N, Z, Z, 8'h00);
        add(H, H, LIN, H, CLA, Z, Z, Z, P0, N, N, N, Z, H, 8'hA0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            m0_cyc = vecs[i].c0; m0_cti = vecs[i].t0;
            m1_cyc = vecs[i].c1; m1_cti = vecs[i].t1;
            s_ack = vecs[i].ack; s_err = vecs[i].err; s_rty = vecs[i].rty;
            #3;
            chk("grant", i, 32'(grant_o), 32'(vecs[i].g));
            chk("ack", i, 32'({m1_ack_o, m0_ack_o}), 32'(vecs[i].a));
            chk("err", i, 32'({m1_err_o, m0_err_o}), 32'(vecs[i].e));
            chk("rty", i, 32'({m1_rty_o, m0_rty_o}), 32'(vecs[i].r));
            chk("timeout", i, 32'(timeout_o), 32'(vecs[i].to));
            chk("s_cyc", i, 32'(s_cyc_o), 32'(vecs[i].sc));
            chk("s_adr", i, s_adr_o, 32'(vecs[i].adr));
            @(posedge clk);
            #1;
        end

        // m0 owns the bus here: check the remaining muxed fields and the data broadcast
        s_dat = 32'hCAFEF00D;
        #1;
        chk("s_dat", 900, s_dat_o, 32'h11110000);
        chk("s_sel", 901, 32'(s_sel_o), 32'hF);
        chk("s_we", 902, 32'(s_we_o), 32'h1);
        chk("s_stb", 903, 32'(s_stb_o), 32'h1);
        chk("s_cti", 904, 32'(s_cti_o), 32'h2);
        chk("s_bte", 905, 32'(s_bte_o), 32'h1);
        chk("m0_dat", 906, m0_dat_o, 32'hCAFEF00D);
        chk("m1_dat", 907, m1_dat_o, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stream_arbiter.md
WB_STREAM_ARBITER -- requirements
Module: wb_stream_arbiter

Interface
REQ-001 Parameter WB_AW, default 32, Wishbone address width.
REQ-002 Parameter WB_DW, default 32, Wishbone data width.
REQ-003 Parameter STALL_MAX, default 256, cycles without slave response before forced release; 0 disables the watchdog.
REQ-004 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-006 m0_adr_i/m0_dat_i/m0_sel_i/m0_we_i/m0_cyc_i/m0_stb_i/m0_cti_i/m0_bte_i  in  WB_AW/WB_DW/WB_DW/8/1/1/1/3/2  master 0 request.
REQ-007 m0_dat_o/m0_ack_o/m0_err_o/m0_rty_o  out  WB_DW/1/1/1  master 0 response.
REQ-008 m1_* ports identical to m0_*, for master 1 (stream reader or second writer).
REQ-009 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o  out  as REQ-006  shared slave request.
REQ-010 s_dat_i/s_ack_i/s_err_i/s_rty_i  in  WB_DW/1/1/1  shared slave response.
REQ-011 grant_o  out  2  one-hot current owner; 00 when idle.
REQ-012 timeout_o  out  1  one-cycle pulse on watchdog release.

Function
REQ-013 FSM states IDLE, OWN0, OWN1; grant_o SHALL equal {OWN1, OWN0}.
REQ-014 IDLE: only m0_cyc_i -> OWN0; only m1_cyc_i -> OWN1; both -> the master not equal to last_owner; neither -> stay IDLE.
REQ-015 Grant SHALL be registered: first slave cycle of a new owner occurs the cycle after the request is seen in IDLE (1-cycle arbitration latency).
REQ-016 In OWNx, all s_* request outputs SHALL be combinationally muxed from mx_*; in IDLE s_cyc_o=s_stb_o=0, s_cti_o=000, other s_* outputs 0.
REQ-017 s_dat_i SHALL be broadcast to both mx_dat_o; ack/err/rty SHALL route only to the owner, 0 to the other.
REQ-018 Release event in OWNx: owner mx_cyc_i low; or s_ack_i with owner cti=111; or s_err_i; or s_rty_i; or watchdog expiry.
REQ-019 On release, if the other master's cyc is high the FSM SHALL move directly to its OWN state; else if owner cyc still high it SHALL retain ownership; else IDLE.
REQ-020 last_owner SHALL update to x at each release from OWNx.
REQ-021 Classic cycles (cti=000) SHALL release on each ack so a streaming master cannot starve the other.
REQ-022 Watchdog: counter clears on entering OWNx and on any s_ack_i/s_err_i/s_rty_i, increments otherwise while owned; at count==STALL_MAX-1 it SHALL release, drive mx_err_o=1 to the owner and pulse timeout_o for that one cycle.
REQ-023 Watchdog counter width SHALL be $clog2(STALL_MAX+1), saturating, never wrapping.
REQ-024 Slave response arriving in IDLE SHALL be dropped (no master ack).
REQ-025 Simultaneous watchdog expiry and s_ack_i: ack SHALL win, no err, no timeout_o.

Reset
REQ-026 While wb_rst_ni=0 at a clock edge: state=IDLE, last_owner=1 (master 0 wins first tie), watchdog=0, timeout_o=0.
REQ-027 Reset mid-burst SHALL drop s_cyc_o low the cycle after the reset edge; no ack forwarded during reset.

Structure
REQ-028 State encodings and CTI constants (CLASSIC 000, LINEAR 010, EOB 111) SHALL live in the shared wb_stream package used by the streamer blocks.
REQ-029 Optional sub-module wb_stream_watchdog (counter + expiry); all else flat.

Verification
REQ-030 Reset, m0 only issues 4-beat linear burst -> grant_o=01 one cycle later, 4 acks to m0, m1 sees none, then IDLE.
REQ-031 Both request from IDLE after reset -> m0 granted first; m0 ends burst (cti=111 ack) with cyc still high -> OWN1 next cycle.
REQ-032 m0 classic reads back-to-back, m1 requesting -> grants alternate 01,10,01 on each ack.
REQ-033 STALL_MAX=8, slave never acks -> after 8 owned cycles m0_err_o=1 and timeout_o=1 for one cycle, then IDLE.
REQ-034 Ack on the expiry cycle -> ack delivered, no err, no timeout_o.
REQ-035 wb_rst_ni low mid-burst on beat 2 -> s_cyc_o=0 next cycle, grant_o=00, last_owner=1.
